// File: rtl/commit_monitor.sv
// commit_monitor: writeback-end retirement monitor.
// Stamps every accepted retirement with a 64-bit order number, checks PC
// continuity between consecutive retirements, detects the self-loop halt
// idiom and buffers packets in a small FIFO for a ready/valid consumer.
module commit_monitor #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_commit,
    input  logic        in_trap,
    input  logic [31:0] in_pc_rdata,
    input  logic [31:0] in_pc_wdata,
    input  logic [31:0] in_insn,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_order,
    output logic [31:0] out_pc_rdata,
    output logic [31:0] out_pc_wdata,
    output logic [31:0] out_insn,
    output logic        halt,
    output logic        err_pc,
    output logic        err_overflow,
    output logic        err_trap,
    output logic [31:0] retired
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] insn;
    } entry_t;

    state_t      state_r;
    state_t      state_nxt_s;
    entry_t      mem_r [DEPTH];
    entry_t      head_s;
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [AW:0] count_s;
    logic        full_s;
    logic        empty_s;
    logic        pop_s;
    logic        space_s;
    logic        accept_s;
    logic        overflow_s;
    logic        pc_mismatch_s;
    logic        is_halt_s;
    logic [63:0] order_r;
    logic [31:0] retired_r;
    logic [31:0] exp_pc_r;
    logic        exp_pc_valid_r;
    logic        halt_r;
    logic        err_pc_r;
    logic        err_overflow_r;
    logic        err_trap_r;

    // FIFO occupancy is the pointer difference; the extra wrap bit separates full from empty.
    assign count_s  = wr_ptr_r - rd_ptr_r;
    assign full_s   = (count_s == DEPTH_C);
    assign empty_s  = (count_s == {(AW + 1){1'b0}});
    assign pop_s    = !empty_s && out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign space_s  = !full_s || pop_s;

    assign accept_s      = (state_r == ST_RUN) && in_commit && space_s;
    assign overflow_s    = (state_r == ST_RUN) && in_commit && !space_s;
    assign pc_mismatch_s = accept_s && exp_pc_valid_r && (in_pc_rdata != exp_pc_r);
    assign is_halt_s     = accept_s && (in_pc_wdata == in_pc_rdata);

    // Head entry always comes straight from storage at the read pointer.
    assign head_s       = mem_r[rd_ptr_r[AW-1:0]];
    assign out_valid    = !empty_s;
    assign out_order    = head_s.order;
    assign out_pc_rdata = head_s.pc_rdata;
    assign out_pc_wdata = head_s.pc_wdata;
    assign out_insn     = head_s.insn;
    assign halt         = halt_r;
    assign err_pc       = err_pc_r;
    assign err_overflow = err_overflow_r;
    assign err_trap     = err_trap_r;
    assign retired      = retired_r;

    // Run/halt state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: a self-looping retirement halts the monitor until reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (is_halt_s) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALTED: state_nxt_s = ST_HALTED;
            default:   state_nxt_s = ST_RUN;
        endcase
    end

    // FIFO storage and pointers; storage is cleared so out_* reads zero after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{64'd0, 32'd0, 32'd0, 32'd0};
            end
            wr_ptr_r <= {(AW + 1){1'b0}};
            rd_ptr_r <= {(AW + 1){1'b0}};
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= '{order_r, in_pc_rdata, in_pc_wdata, in_insn};
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Order/retired counters and the expected-PC tracker advance only on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            order_r        <= 64'd0;
            retired_r      <= 32'd0;
            exp_pc_r       <= 32'd0;
            exp_pc_valid_r <= 1'b0;
        end else if (accept_s) begin
            order_r        <= order_r + 64'd1;
            retired_r      <= retired_r + 32'd1;
            exp_pc_r       <= in_pc_wdata;
            exp_pc_valid_r <= 1'b1;
        end
    end

    // Sticky status flags; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_r         <= 1'b0;
            err_pc_r       <= 1'b0;
            err_overflow_r <= 1'b0;
            err_trap_r     <= 1'b0;
        end else begin
            if (is_halt_s)     halt_r         <= 1'b1;
            if (pc_mismatch_s) err_pc_r       <= 1'b1;
            if (overflow_s)    err_overflow_r <= 1'b1;
            if (in_trap)       err_trap_r     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_commit_monitor.sv
// Directed self-checking bench for commit_monitor (DEPTH = 4).
module tb_commit_monitor;

    logic        clk;
    logic        rst;
    logic        in_commit;
    logic        in_trap;
    logic [31:0] in_pc_rdata;
    logic [31:0] in_pc_wdata;
    logic [31:0] in_insn;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_order;
    logic [31:0] out_pc_rdata;
    logic [31:0] out_pc_wdata;
    logic [31:0] out_insn;
    logic        halt;
    logic        err_pc;
    logic        err_overflow;
    logic        err_trap;
    logic [31:0] retired;

    int n_checks;
    int n_pass;

    commit_monitor #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_commit    (in_commit),
        .in_trap      (in_trap),
        .in_pc_rdata  (in_pc_rdata),
        .in_pc_wdata  (in_pc_wdata),
        .in_insn      (in_insn),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_order    (out_order),
        .out_pc_rdata (out_pc_rdata),
        .out_pc_wdata (out_pc_wdata),
        .out_insn     (out_insn),
        .halt         (halt),
        .err_pc       (err_pc),
        .err_overflow (err_overflow),
        .err_trap     (err_trap),
        .retired      (retired)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic [31:0] pc, input logic [31:0] npc,
                         input logic [31:0] insn);
        in_commit   = c;
        in_pc_rdata = pc;
        in_pc_wdata = npc;
        in_insn     = insn;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        in_trap = 1'b0;
    endtask

    // Pulse reset between edges and check that outputs clear immediately.
    task automatic pulse_reset(input string tag);
        rst = 1'b0;
        #1;
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_retired"}, {32'd0, retired}, 64'd0);
        check({tag, "_flags"}, {60'd0, halt, err_pc, err_overflow, err_trap}, 64'd0);
        rst = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b0;
        out_ready = 1'b0;
        idle();
        #12;
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_order", out_order, 64'd0);
        check("rst_retired", {32'd0, retired}, 64'd0);
        check("rst_flags", {60'd0, halt, err_pc, err_overflow, err_trap}, 64'd0);
        rst = 1'b1;
        step();

        // Sequential stream, consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h60 + 32'(4 * i), 32'h64 + 32'(4 * i), 32'h13);
            step();
            check("seq_valid", {63'd0, out_valid}, 64'd1);
            check("seq_order", out_order, 64'(i));
            check("seq_pc", {32'd0, out_pc_rdata}, 64'h60 + 64'(4 * i));
        end
        idle();
        step();
        check("seq_drained", {63'd0, out_valid}, 64'd0);
        check("seq_err_pc", {63'd0, err_pc}, 64'd0);
        check("seq_retired", {32'd0, retired}, 64'd3);

        // Branch discontinuity: 0x60 -> 0x80 expected, but 0x64 retires.
        pulse_reset("rstA");
        step();
        drive(1'b1, 32'h60, 32'h80, 32'h13);
        step();
        check("br_order0", out_order, 64'd0);
        check("br_err_pc_first", {63'd0, err_pc}, 64'd0);
        drive(1'b1, 32'h64, 32'h68, 32'h13);
        step();
        check("br_order1", out_order, 64'd1);
        check("br_err_pc", {63'd0, err_pc}, 64'd1);
        idle();
        step();

        // Backpressure and overflow.
        pulse_reset("rstB");
        out_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h200 + 32'(4 * i), 32'h204 + 32'(4 * i), 32'h13);
            step();
        end
        check("ovf_flag", {63'd0, err_overflow}, 64'd1);
        check("ovf_retired", {32'd0, retired}, 64'd4);
        check("ovf_head", out_order, 64'd0);
        check("ovf_head_stable", {32'd0, out_pc_rdata}, 64'h200);
        // Full FIFO with a simultaneous pop still accepts.
        out_ready = 1'b1;
        drive(1'b1, 32'h210, 32'h214, 32'h33);
        step();
        check("ovf_pop_push_head", out_order, 64'd1);
        check("ovf_pop_push_retired", {32'd0, retired}, 64'd5);
        check("ovf_err_pc", {63'd0, err_pc}, 64'd0);
        idle();
        for (int i = 1; i < 5; i++) begin
            check("ovf_drain_order", out_order, 64'(i));
            step();
        end
        check("ovf_drained", {63'd0, out_valid}, 64'd0);

        // Reset mid-stream with sticky flag set and entries queued.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h220 + 32'(4 * i), 32'h224 + 32'(4 * i), 32'h13);
            step();
        end
        check("mid_queued", {63'd0, out_valid}, 64'd1);
        idle();
        pulse_reset("rstC");
        step();
        drive(1'b1, 32'h400, 32'h404, 32'h13);
        step();
        check("mid_first_order", out_order, 64'd0);
        check("mid_first_pc", {32'd0, out_pc_rdata}, 64'h400);
        idle();

        // Halt idiom.
        pulse_reset("rstD");
        step();
        drive(1'b1, 32'h100, 32'h100, 32'h0000006f);
        step();
        check("halt_flag", {63'd0, halt}, 64'd1);
        check("halt_insn", {32'd0, out_insn}, 64'h6f);
        check("halt_retired", {32'd0, retired}, 64'd1);
        drive(1'b1, 32'h104, 32'h108, 32'h13);
        step();
        check("halt_ignored_retired", {32'd0, retired}, 64'd1);
        check("halt_ignored_pc", {63'd0, err_pc}, 64'd0);
        idle();
        out_ready = 1'b1;
        step();
        check("halt_one_entry", {63'd0, out_valid}, 64'd0);

        // Trap without commit.
        pulse_reset("rstE");
        step();
        in_trap = 1'b1;
        step();
        in_trap = 1'b0;
        check("trap_flag", {63'd0, err_trap}, 64'd1);
        check("trap_no_push", {63'd0, out_valid}, 64'd0);
        check("trap_retired", {32'd0, retired}, 64'd0);
        out_ready = 1'b0;
        drive(1'b1, 32'h300, 32'h304, 32'h13);
        step();
        check("trap_order", out_order, 64'd0);
        check("trap_sticky", {63'd0, err_trap}, 64'd1);
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
